// File: rtl/coeff_bank_streamer_pkg.sv
// Shared definitions for the coefficient bank streamer: defaults, FSM states
// and the width helper used to size address and bank fields.
package coeff_bank_streamer_pkg;

  localparam int unsigned DEF_LENGTH     = 20;
  localparam int unsigned DEF_DATA_WIDTH = 18;
  localparam int unsigned DEF_NUM_BANKS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // ceil(log2(n)) with a floor of one bit so single-entry fields stay legal
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/coeff_bank_ram.sv
// Flat coefficient store for all banks: one write port, one registered read
// port whose output register holds its value while no read is requested.
module coeff_bank_ram #(
  parameter int unsigned DEPTH      = 40,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] r_rd_data;

  // Storage is deliberately never reset so contents survive a reset
  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n)   r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/coeff_bank_streamer.sv
// Streams one coefficient set per start from a selectable bank over a
// valid/ready handshake, with optional looping and guarded bank reloads.
module coeff_bank_streamer
  import coeff_bank_streamer_pkg::*;
#(
  parameter  int unsigned LENGTH     = DEF_LENGTH,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  localparam int unsigned ADDR_W     = width_of(LENGTH),
  localparam int unsigned BANK_W     = width_of(NUM_BANKS)
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_wr_en,
  input  logic [BANK_W-1:0]            i_wr_bank,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  output logic                         o_wr_err,
  input  logic                         i_start,
  input  logic [BANK_W-1:0]            i_bank_sel,
  input  logic                         i_loop_mode,
  input  logic                         i_stop,
  output logic                         o_coeff_valid,
  input  logic                         i_coeff_ready,
  output logic signed [DATA_WIDTH-1:0] o_coeff_out,
  output logic [ADDR_W-1:0]            o_coeff_index,
  output logic                         o_coeff_last,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned DEPTH    = NUM_BANKS * LENGTH;
  localparam int unsigned RAM_AW   = width_of(DEPTH);
  localparam int unsigned LAST_IDX = LENGTH - 1;

  state_e              r_state;
  logic                r_valid, r_last, r_busy, r_done, r_wr_err, r_loop;
  logic [ADDR_W-1:0]   r_index;
  logic [BANK_W-1:0]   r_bank;

  logic                w_start_ok, w_accept, w_at_last, w_wr_ok, w_wr_rej, w_rd_en;
  logic [BANK_W-1:0]   w_rd_bank;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic [RAM_AW-1:0]   w_rd_addr, w_wr_addr;

  assign w_start_ok = (r_state == ST_IDLE) && i_start && (32'(i_bank_sel) < NUM_BANKS);
  assign w_accept   = r_valid && i_coeff_ready;
  assign w_at_last  = (32'(r_index) == LAST_IDX);

  // Fetch the beat that will be presented after this edge
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_bank = r_bank;
    w_rd_idx  = '0;
    if (w_start_ok) begin
      w_rd_en   = 1'b1;
      w_rd_bank = i_bank_sel;
    end else if ((r_state == ST_STREAM) && w_accept && !i_stop) begin
      if (!w_at_last) begin
        w_rd_en  = 1'b1;
        w_rd_idx = r_index + ADDR_W'(1);
      end else if (r_loop) begin
        w_rd_en = 1'b1;
      end
    end
  end

  assign w_rd_addr = RAM_AW'(32'(w_rd_bank) * LENGTH + 32'(w_rd_idx));
  assign w_wr_addr = RAM_AW'(32'(i_wr_bank) * LENGTH + 32'(i_wr_addr));

  // The bank being streamed (or about to be) is locked against writes
  assign w_wr_ok  = i_wr_en
                 && (32'(i_wr_addr) < LENGTH)
                 && (32'(i_wr_bank) < NUM_BANKS)
                 && !(r_busy && (i_wr_bank == r_bank))
                 && !(w_start_ok && (i_wr_bank == i_bank_sel));
  assign w_wr_rej = i_wr_en && !w_wr_ok;

  coeff_bank_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (RAM_AW)
  ) u_ram (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_wr_en   (w_wr_ok && i_reset_n),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (o_coeff_out)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      r_bank   <= '0;
      r_loop   <= 1'b0;
    end else begin
      r_wr_err <= w_wr_rej;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state <= ST_STREAM;
            r_bank  <= i_bank_sel;
            r_loop  <= i_loop_mode;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_index <= '0;
            r_last  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_accept) begin
            if (!w_at_last) begin
              r_index <= r_index + ADDR_W'(1);
              r_last  <= (32'(r_index) + 32'd1 == LAST_IDX);
            end else if (r_loop) begin
              // Gapless wrap; loop mode is re-sampled for the next pass
              r_index <= '0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_loop  <= i_loop_mode;
            end else begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_coeff_valid = r_valid;
  assign o_coeff_index = r_index;
  assign o_coeff_last  = r_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_wr_err      = r_wr_err;

endmodule
